// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and address-space defaults for the pc sequencer,
// branch unit target table and instruction memory.
package pc_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int PC_W_DEF     = 10;
    localparam int START_PC_DEF = 0;
    localparam int CNT_W_DEF    = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
// Ports: clk, reset (sync, active-high), clr (sync clear), inc (count enable), cnt (value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk)
        if (reset || clr) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and IDLE/RUN/DONE run control with start/done host handshake.
// Ports: clk, reset (sync, active-high); start, stall, halt_instr, branch, branch_target in;
// pc, running, done, overflow, cycle_count out; taken_count out when BRANCH_STATS_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int START_PC = START_PC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_instr,
    input  logic             branch,
    input  logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic             overflow,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0] taken_count,
`endif
    output logic [CNT_W-1:0] cycle_count
);
    state_t          state, state_n;
    logic [PC_W-1:0] pc_n;
    logic            overflow_n;
    logic            load;
    logic            in_run;

    assign in_run  = state == RUN;
    assign load    = start && !in_run;
    assign running = in_run;
    assign done    = state == DONE;

    always_ff @(posedge clk)
        if (reset) begin
            state    <= IDLE;
            pc       <= PC_W'(START_PC);
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            overflow <= overflow_n;
        end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        overflow_n = overflow;
        if (load) begin
            state_n    = RUN;
            pc_n       = PC_W'(START_PC);
            overflow_n = 1'b0;
        end else if (in_run && !stall) begin
            if (halt_instr) state_n = DONE;
            else if (branch) pc_n = branch_target;
            // Stop at the top of memory instead of silently wrapping to 0.
            else if (&pc) begin
                state_n    = DONE;
                overflow_n = 1'b1;
            end else pc_n = pc + 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk(clk), .reset(reset), .clr(load), .inc(in_run), .cnt(cycle_count)
    );

`ifdef BRANCH_STATS_EN
    sat_counter #(.W(CNT_W)) u_taken (
        .clk(clk), .reset(reset), .clr(load),
        .inc(in_run && !stall && !halt_instr && branch), .cnt(taken_count)
    );
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        halt_instr = 1'b0;
    logic        branch = 1'b0;
    logic [9:0]  branch_target = '0;
    logic [9:0]  pc;
    logic        running, done, overflow;
    logic [15:0] cycle_count;
    logic [15:0] taken_count;

    typedef struct {
        logic [9:0]  pc;
        logic        run;
        logic        dn;
        logic        ovf;
        logic [15:0] cc;
        logic [15:0] tk;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_instr(halt_instr),
        .branch(branch), .branch_target(branch_target), .pc(pc), .running(running),
        .done(done), .overflow(overflow),
`ifdef BRANCH_STATS_EN
        .taken_count(taken_count),
`endif
        .cycle_count(cycle_count)
    );

`ifndef BRANCH_STATS_EN
    assign taken_count = '0;
`endif

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every posedge, once outputs settle, compare against the oldest expectation.
    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", int'(pc), int'(e.pc));
            chk("running", int'(running), int'(e.run));
            chk("done", int'(done), int'(e.dn));
            chk("overflow", int'(overflow), int'(e.ovf));
            chk("cycle_count", int'(cycle_count), int'(e.cc));
`ifdef BRANCH_STATS_EN
            chk("taken_count", int'(taken_count), int'(e.tk));
`endif
        end
    end

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input logic r, s, st, h, b, input int t,
                        input int e_pc, e_run, e_dn, e_ovf, e_cc, e_tk);
        exp_t e;
        @(negedge clk);
        reset = r; start = s; stall = st; halt_instr = h; branch = b;
        branch_target = 10'(t);
        e.pc = 10'(e_pc); e.run = 1'(e_run); e.dn = 1'(e_dn); e.ovf = 1'(e_ovf);
        e.cc = 16'(e_cc); e.tk = 16'(e_tk);
        exp_q.push_back(e);
    endtask

    initial begin
        //    r s st h b tgt    pc  run dn ovf cc tk
        step(1,0,0,0,0,   0,    0,  0,  0, 0,  0, 0);
        step(1,0,0,0,0,   0,    0,  0,  0, 0,  0, 0);
        step(0,0,0,0,0,   0,    0,  0,  0, 0,  0, 0);
        step(0,1,0,0,0,   0,    0,  1,  0, 0,  0, 0);
        for (int i = 1; i <= 5; i++)
            step(0,0,0,0,0, 0,  i,  1,  0, 0,  i, 0);
        step(0,0,0,0,1,  16,   16,  1,  0, 0,  6, 1);
        step(0,0,0,0,0,   0,   17,  1,  0, 0,  7, 1);
        step(0,0,0,0,1,   7,    7,  1,  0, 0,  8, 2);
        step(0,0,1,0,1,  20,    7,  1,  0, 0,  9, 2);
        step(0,0,1,1,1,  20,    7,  1,  0, 0, 10, 2);
        step(0,0,1,0,1,  20,    7,  1,  0, 0, 11, 2);
        step(0,0,0,0,1,  20,   20,  1,  0, 0, 12, 3);
        step(0,0,0,1,1,  50,   20,  0,  1, 0, 13, 3);
        step(0,0,0,0,1,  50,   20,  0,  1, 0, 13, 3);
        step(0,1,0,0,0,   0,    0,  1,  0, 0,  0, 0);
        step(0,0,0,0,1,1023, 1023,  1,  0, 0,  1, 1);
        step(0,0,0,0,0,   0, 1023,  0,  1, 1,  2, 1);
        step(0,0,0,0,0,   0, 1023,  0,  1, 1,  2, 1);
        step(0,1,0,0,0,   0,    0,  1,  0, 0,  0, 0);
        step(0,1,0,0,0,   0,    1,  1,  0, 0,  1, 0);
        step(0,0,0,0,1,  40,   40,  1,  0, 0,  2, 1);
        step(1,1,0,0,0,   0,    0,  0,  0, 0,  0, 0);
        step(0,0,0,0,1,   9,    0,  0,  0, 0,  0, 0);
        step(0,0,0,0,0,   0,    0,  0,  0, 0,  0, 0);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
